mem_job_sequencer: RTL
======================

Name: mem_job_sequencer

Overview:
- Sequences the shared RAM master controller on behalf of the mining core. Polls the host (atom) flag word, burst-reads the 24-word mining block, and hands the words to the miner.
- Consumes the host flag, waits for a nonce from the miner, then writes the nonce and a done flag back.
- Sits between the RAM master controller's user-logic port and the miner datapath. It is the only issuer of RAM commands in the design.

Parameters:
- FLAG_ATOM_ADDR, 28'h8000000, host-to-FPGA flag word address
- FLAG_HW_ADDR, 28'h8000004, FPGA-to-host flag word address
- BLOCK_ADDR, 28'h8000008, first word of the mining block
- NONCE_ADDR, 28'h8000068, nonce result word (96 bytes after BLOCK_ADDR)
- BLOCK_WORDS, 24, number of 32-bit block words
- NEW_JOB_MAGIC, 32'hAAAA0000, flag value meaning "new job ready"
- DONE_MAGIC, 32'hBBBB0000, value written to FLAG_HW_ADDR when the nonce is posted
- POLL_GAP, 16, idle cycles between flag polls (minimum 1)
- TIMEOUT, 1024, max cycles waiting for one RAM transaction

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- mc_go  out  1  one-cycle command strobe to the RAM controller
- mc_rdwr  out  1  0 = read, 1 = write; valid while mc_go is high
- mc_addr  out  28  byte address; valid while mc_go is high
- mc_wdata  out  32  write data; valid while mc_go is high
- mc_rdata_valid  in  1  read data available (one-cycle pulse)
- mc_rdata  in  32  read data, valid with mc_rdata_valid
- mc_wr_done  in  1  write complete (one-cycle pulse)
- blk_word  out  32  block word to the miner
- blk_idx  out  5  index of blk_word (0..BLOCK_WORDS-1)
- blk_valid  out  1  one-cycle strobe: blk_word and blk_idx are valid
- job_start  out  1  one-cycle pulse after the full block is loaded and the flag is consumed
- nonce_valid  in  1  miner holds this high until nonce_accept
- nonce  in  32  found nonce, stable while nonce_valid is high
- nonce_accept  out  1  one-cycle pulse: nonce latched
- busy  out  1  high in every state except IDLE
- err  out  1  sticky transaction-timeout flag, cleared only by reset
- jobs_done  out  16  count of completed jobs; wraps 16'hFFFF -> 0

Behaviour:
- Reset (reset == 0 at posedge clk):
  - state = IDLE; gap counter, word index and timeout counter = 0.
  - All outputs = 0, including err and jobs_done.
  - Reset mid-transaction abandons it. Any late mc_rdata_valid or mc_wr_done after reset is ignored.
- Command rule: exactly one outstanding transaction. mc_go is high for exactly one cycle, in the cycle a *_REQ state is occupied. The matching *_WAIT state follows.
- Completion ignored outside WAIT: mc_rdata_valid in a non-read-WAIT state and mc_wr_done in a non-write-WAIT state are ignored.
- Timeout counter: reset on entry to each WAIT state. If it reaches TIMEOUT without completion, set err = 1 and go to IDLE. jobs_done is unchanged and the block is not re-sent.
- States:
  - IDLE: count POLL_GAP cycles, then go to POLL_REQ.
  - POLL_REQ: read at FLAG_ATOM_ADDR; go to POLL_WAIT.
  - POLL_WAIT: on mc_rdata_valid, if mc_rdata == NEW_JOB_MAGIC set idx = 0 and go to BLK_REQ; otherwise go to IDLE.
  - BLK_REQ: read at BLOCK_ADDR + 4*idx (28-bit add, idx zero-extended); go to BLK_WAIT.
  - BLK_WAIT: on mc_rdata_valid, in the same cycle set blk_word = mc_rdata, blk_idx = idx, blk_valid = 1.
    - If idx == BLOCK_WORDS-1, go to CLR_REQ.
    - Otherwise idx++ and go to BLK_REQ.
  - CLR_REQ: write 32'h0 to FLAG_ATOM_ADDR (consumes the job); go to CLR_WAIT.
  - CLR_WAIT: on mc_wr_done, pulse job_start and go to MINING.
  - MINING: no RAM traffic. When nonce_valid is high, latch nonce, pulse nonce_accept and go to NONCE_REQ.
  - NONCE_REQ: write the latched nonce to NONCE_ADDR; go to NONCE_WAIT.
  - NONCE_WAIT: on mc_wr_done, go to DONE_REQ.
  - DONE_REQ: write DONE_MAGIC to FLAG_HW_ADDR; go to DONE_WAIT.
  - DONE_WAIT: on mc_wr_done, jobs_done++ and go to IDLE.
- Nonce handshake:
  - nonce_valid outside MINING is not accepted; the miner keeps holding it.
  - nonce_accept occurs at most once per job.
  - MINING has no timeout.
- Registered outputs: blk_* and job_start are registered; minimum latency from completion pulse to strobe is 1 cycle.
- Minimum cycles, flag read to first block word request: 2 (POLL_WAIT completion, then BLK_REQ).

Test Plan:
- Flag poll miss: reset, flag read returns 32'h00000000 -> return to IDLE, next mc_go after POLL_GAP=16 idle cycles at address 28'h8000000; no blk_valid.
- Full job: flag read returns 32'hAAAA0000 and block reads return 32'h100+i.
  - Exactly 24 blk_valid strobes, blk_idx 0..23, blk_word 32'h100..32'h117.
  - Read addresses 28'h8000008..28'h8000064 in steps of 4.
  - Then a write of 0 to 28'h8000000, then job_start.
- Nonce post: in MINING, drive nonce_valid with nonce 32'hDEADBEEF.
  - nonce_accept pulses once.
  - Write 32'hDEADBEEF to 28'h8000068, then 32'hBBBB0000 to 28'h8000004; jobs_done = 1, busy = 0.
- Spurious and early inputs: mc_rdata_valid pulse during IDLE and nonce_valid high during BLK_WAIT -> ignored; nonce accepted only after job_start.
- Timeout: withhold mc_rdata_valid in BLK_WAIT for 1024 cycles -> err = 1, state IDLE, jobs_done unchanged; err stays 1 through a later successful job.
- Reset mid-block: assert reset at word 10 -> next cycle all outputs 0; a late mc_rdata_valid produces no blk_valid; a fresh poll starts at address 28'h8000000.

Source files
------------

// File: rtl/mem_job_sequencer.sv
// Drives the RAM master on behalf of the miner: polls the host flag, streams the block,
// consumes the job, then posts the nonce and done flag. One RAM transaction outstanding at a time.
module mem_job_sequencer #(
  parameter logic [27:0] FLAG_ATOM_ADDR = 28'h8000000,
  parameter logic [27:0] FLAG_HW_ADDR   = 28'h8000004,
  parameter logic [27:0] BLOCK_ADDR     = 28'h8000008,
  parameter logic [27:0] NONCE_ADDR     = 28'h8000068,
  parameter int unsigned BLOCK_WORDS    = 24,
  parameter logic [31:0] NEW_JOB_MAGIC  = 32'hAAAA0000,
  parameter logic [31:0] DONE_MAGIC     = 32'hBBBB0000,
  parameter int unsigned POLL_GAP       = 16,
  parameter int unsigned TIMEOUT        = 1024
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mc_go,
  output logic        mc_rdwr,
  output logic [27:0] mc_addr,
  output logic [31:0] mc_wdata,
  input  logic        mc_rdata_valid,
  input  logic [31:0] mc_rdata,
  input  logic        mc_wr_done,
  output logic [31:0] blk_word,
  output logic [4:0]  blk_idx,
  output logic        blk_valid,
  output logic        job_start,
  input  logic        nonce_valid,
  input  logic [31:0] nonce,
  output logic        nonce_accept,
  output logic        busy,
  output logic        err,
  output logic [15:0] jobs_done
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    IDLE, POLL_REQ, POLL_WAIT, BLK_REQ, BLK_WAIT, CLR_REQ, CLR_WAIT,
    MINING, NONCE_REQ, NONCE_WAIT, DONE_REQ, DONE_WAIT
  } state_t;

  state_t        state;
  logic [15:0]   gap_cnt;
  logic [4:0]    idx;
  logic [TW-1:0] tmo_cnt;
  logic          rd_wait;
  logic          wr_wait;
  logic          completed;
  logic [4:0]    idx_next;

  assign rd_wait   = (state == POLL_WAIT) || (state == BLK_WAIT);
  assign wr_wait   = (state == CLR_WAIT) || (state == NONCE_WAIT) || (state == DONE_WAIT);
  assign completed = (rd_wait && mc_rdata_valid) || (wr_wait && mc_wr_done);
  assign idx_next  = idx + 5'd1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      gap_cnt      <= '0;
      idx          <= '0;
      tmo_cnt      <= '0;
      mc_go        <= 1'b0;
      mc_rdwr      <= 1'b0;
      mc_addr      <= '0;
      mc_wdata     <= '0;
      blk_word     <= '0;
      blk_idx      <= '0;
      blk_valid    <= 1'b0;
      job_start    <= 1'b0;
      nonce_accept <= 1'b0;
      busy         <= 1'b0;
      err          <= 1'b0;
      jobs_done    <= '0;
    end else begin
      mc_go        <= 1'b0;
      blk_valid    <= 1'b0;
      job_start    <= 1'b0;
      nonce_accept <= 1'b0;
      if ((rd_wait || wr_wait) && !completed) begin
        // Abandon a stuck transaction; the job is dropped, not retried or counted.
        if (tmo_cnt == TW'(TIMEOUT - 1)) begin
          err     <= 1'b1;
          state   <= IDLE;
          busy    <= 1'b0;
          gap_cnt <= '0;
        end else begin
          tmo_cnt <= tmo_cnt + TW'(1);
        end
      end else begin
        unique case (state)
          IDLE: begin
            if (gap_cnt == 16'(POLL_GAP - 1)) begin
              gap_cnt  <= '0;
              state    <= POLL_REQ;
              busy     <= 1'b1;
              mc_go    <= 1'b1;
              mc_rdwr  <= 1'b0;
              mc_addr  <= FLAG_ATOM_ADDR;
              mc_wdata <= '0;
            end else begin
              gap_cnt <= gap_cnt + 16'd1;
            end
          end
          POLL_REQ:  begin state <= POLL_WAIT;  tmo_cnt <= '0; end
          BLK_REQ:   begin state <= BLK_WAIT;   tmo_cnt <= '0; end
          CLR_REQ:   begin state <= CLR_WAIT;   tmo_cnt <= '0; end
          NONCE_REQ: begin state <= NONCE_WAIT; tmo_cnt <= '0; end
          DONE_REQ:  begin state <= DONE_WAIT;  tmo_cnt <= '0; end
          POLL_WAIT: begin
            if (mc_rdata == NEW_JOB_MAGIC) begin
              idx      <= '0;
              state    <= BLK_REQ;
              mc_go    <= 1'b1;
              mc_rdwr  <= 1'b0;
              mc_addr  <= BLOCK_ADDR;
              mc_wdata <= '0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
          BLK_WAIT: begin
            blk_word  <= mc_rdata;
            blk_idx   <= idx;
            blk_valid <= 1'b1;
            mc_go     <= 1'b1;
            if (idx == 5'(BLOCK_WORDS - 1)) begin
              state    <= CLR_REQ;
              mc_rdwr  <= 1'b1;
              mc_addr  <= FLAG_ATOM_ADDR;
              mc_wdata <= '0;
            end else begin
              idx      <= idx_next;
              state    <= BLK_REQ;
              mc_rdwr  <= 1'b0;
              mc_addr  <= BLOCK_ADDR + {21'd0, idx_next, 2'b00};
              mc_wdata <= '0;
            end
          end
          CLR_WAIT: begin
            job_start <= 1'b1;
            state     <= MINING;
          end
          MINING: begin
            // The nonce is latched straight into the write-data register.
            if (nonce_valid) begin
              nonce_accept <= 1'b1;
              state        <= NONCE_REQ;
              mc_go        <= 1'b1;
              mc_rdwr      <= 1'b1;
              mc_addr      <= NONCE_ADDR;
              mc_wdata     <= nonce;
            end
          end
          NONCE_WAIT: begin
            state    <= DONE_REQ;
            mc_go    <= 1'b1;
            mc_rdwr  <= 1'b1;
            mc_addr  <= FLAG_HW_ADDR;
            mc_wdata <= DONE_MAGIC;
          end
          DONE_WAIT: begin
            jobs_done <= jobs_done + 16'd1;
            state     <= IDLE;
            busy      <= 1'b0;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
